// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and constants for the UART instruction loader
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;

endpackage

// File: rtl/rx_gap_timer.sv
// rtl/rx_gap_timer.sv - inter-byte gap counter, cleared by each strobe, expires at TIMEOUT_CYC
module rx_gap_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT so expired stays high until the owner reacts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || clr) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - frames UART bytes into little-endian words for instr_mem port A; optional UART_LOADER_CHECKSUM_EN
module uart_instr_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W     = (ADDR_W+1)'(1);
    localparam logic [1:0]      LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_t          state;
    logic [ADDR_W:0] word_n;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_lo;
    logic            gap_expired;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    rx_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (busy),
        .clr     (rx_valid),
        .expired (gap_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
            word_n    <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_lo    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state     <= ST_LEN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        word_n   <= (rx_data == 8'd0) ? DEPTH : (ADDR_W+1)'(rx_data);
                        word_idx <= '0;
                        byte_idx <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        // Shift right so the first byte of a word ends up in the LSB lane.
                        asm_lo   <= {rx_data, asm_lo[23:8]};
`ifdef UART_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_idx == LAST_LANE) begin
                            mem_we   <= 1'b1;
                            mem_addr <= word_idx[ADDR_W-1:0];
                            mem_din  <= {rx_data, asm_lo};
                            word_idx <= word_idx + ONE_W;
                            if (word_idx + ONE_W == word_n) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                state     <= ST_CSUM;
`else
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cpu_rst_n <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            err       <= 1'b1;
                            cpu_rst_n <= 1'b0;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
            // A byte arriving on the expiry cycle still counts; only a silent cycle aborts.
            if (busy && !rx_valid && gap_expired) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b1;
                cpu_rst_n <= 1'b0;
            end
        end
    end

endmodule
